// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// the default operand width.
package div_pkg;

   // Default operand/result width in bits.
   localparam int DIV_WIDTH = 8;

   // Divider control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WORK = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, then do a
// trial subtract of the divisor. This holds the design's only subtractor.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // The shifted remainder needs WIDTH+1 bits. The MSB of the trial
   // difference is then the borrow, which means "negative".
   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor};

   // Keep the trial result and set the quotient bit only when the subtract did not borrow.
   always_comb begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div.sv
// Iterative unsigned restoring divider (IDLE -> WORK -> DONE).
// Optional macro DIV_ZERO_DETECT_EN: with a zero divisor, skip the
// iterations and report dz_o=1.
module div
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] r_out,
   output logic             busy_o,
   output logic             dz_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state, state_next;
   logic [WIDTH-1:0] rem, quo, divisor;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic [CW-1:0]    cnt;
   logic             iter_done;
   logic             dz_flag;

   // After the last iteration, WORK spends one more edge handing off to
   // DONE. This keeps the latency at WIDTH+2 edges.
   assign iter_done = (cnt == CW'(WIDTH));

`ifdef DIV_ZERO_DETECT_EN
   // Remember whether the accepted divisor was zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dz_flag <= 1'b0;
      else if (state == IDLE && start)
         dz_flag <= (b_in == '0);
   end
`else
   assign dz_flag = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (divisor),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = WORK;
         WORK: if (iter_done || dz_flag) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and output registers. Inputs are sampled only on the accept
   // edge, so later changes to start, a_in or b_in cannot disturb a running
   // operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         cnt     <= '0;
         q_out   <= '0;
         r_out   <= '0;
         busy_o  <= 1'b0;
         dz_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  quo     <= a_in;
                  divisor <= b_in;
                  rem     <= '0;
                  cnt     <= '0;
                  q_out   <= '0;
                  r_out   <= '0;
                  dz_o    <= 1'b0;
                  busy_o  <= 1'b1;
               end
            end
            WORK: begin
               if (!(iter_done || dz_flag)) begin
                  rem <= rem_next;
                  quo <= quo_next;
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               dz_o   <= dz_flag;
               if (dz_flag) begin
                  // quo still holds the untouched dividend.
                  q_out <= '1;
                  r_out <= quo;
               end else begin
                  q_out <= quo;
                  r_out <= rem;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Testbench for div. A latency/arithmetic reference model is checked on
// every clock. Directed operations also pin literal results and busy widths.
module tb_div;

   localparam int W = 8;
`ifdef DIV_ZERO_DETECT_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic [W-1:0] q_out, r_out;
   logic         busy_o, dz_o;

   int errors = 0;
   int checks = 0;

   div #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_in   (a_in),
      .b_in   (b_in),
      .q_out  (q_out),
      .r_out  (r_out),
      .busy_o (busy_o),
      .dz_o   (dz_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an accepted operation keeps busy high for a fixed
   // number of edges. Its result is then plain integer division.
   int           m_left = 0;
   logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
   logic         m_busy = 1'b0, m_dz = 1'b0;

   function automatic int lat(input logic [W-1:0] b);
      if (DZ_EN && b == 0) return 2;
      return W + 2;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_q = '0; m_r = '0; m_busy = 1'b0; m_dz = 1'b0;
      end else if (m_left == 0) begin
         if (start) begin
            m_a = a_in; m_b = b_in; m_left = lat(b_in);
            m_busy = 1'b1; m_q = '0; m_r = '0; m_dz = 1'b0;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            if (m_b == 0) begin
               m_q = '1; m_r = m_a; m_dz = DZ_EN;
            end else begin
               m_q = m_a / m_b; m_r = m_a % m_b;
            end
         end
      end
   end

   // Per-cycle compare against the model.
   always @(posedge clk) begin
      #3;
      if (!rst) begin
         chk("model_busy", int'(busy_o), int'(m_busy));
         chk("model_q",    int'(q_out),  int'(m_q));
         chk("model_r",    int'(r_out),  int'(m_r));
         chk("model_dz",   int'(dz_o),   int'(m_dz));
      end
   end

   // Start one operation and count the negedges on which busy is seen high.
   task automatic op(input int a, input int b, output int bc);
      @(negedge clk);
      a_in = W'(a); b_in = W'(b); start = 1'b1;
      bc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy_o) bc++;
         else break;
      end
   endtask

   task automatic run_op(input string nm, input int a, input int b,
                         input int eq, input int er, input int ebusy, input int edz);
      int bc;
      op(a, b, bc);
      chk({nm, "_busy_clks"}, bc, ebusy);
      chk({nm, "_q"}, int'(q_out), eq);
      chk({nm, "_r"}, int'(r_out), er);
      chk({nm, "_dz"}, int'(dz_o), edz);
   endtask

   initial begin
      int bc;
      #1 rst = 1'b1;
      #1;
      chk("reset_q", int'(q_out), 0);
      chk("reset_r", int'(r_out), 0);
      chk("reset_busy", int'(busy_o), 0);
      chk("reset_dz", int'(dz_o), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Basic operation, boundaries and zero divisor.
      run_op("basic", 100, 7, 14, 2, 10, 0);
      run_op("a255b1", 255, 1, 255, 0, 10, 0);
      run_op("a5b9", 5, 9, 0, 5, 10, 0);
      run_op("a0b3", 0, 3, 0, 0, 10, 0);
      run_op("a255b255", 255, 255, 1, 0, 10, 0);
      run_op("divzero", 77, 0, 255, 77, DZ_EN ? 2 : 10, DZ_EN ? 1 : 0);
      run_op("after_dz", 200, 13, 15, 5, 10, 0);

      // Start pulse and operand change during a running 200/13.
      @(negedge clk);
      a_in = 8'd200; b_in = 8'd13; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; a_in = 8'd9; b_in = 8'd3;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 30 && busy_o; i++) @(negedge clk);
      chk("midop_busy_end", int'(busy_o), 0);
      chk("midop_q", int'(q_out), 15);
      chk("midop_r", int'(r_out), 5);
      repeat (4) @(negedge clk);
      chk("midop_no_second", int'(busy_o), 0);

      // Reset during iteration 4 of 200/13.
      @(negedge clk);
      a_in = 8'd200; b_in = 8'd13; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy_o), 0);
      chk("midrst_q", int'(q_out), 0);
      chk("midrst_r", int'(r_out), 0);
      chk("midrst_dz", int'(dz_o), 0);
      @(negedge clk); rst = 1'b0;
      run_op("post_rst", 200, 13, 15, 5, 10, 0);

      // Start held high across several operations.
      @(negedge clk);
      a_in = 8'd50; b_in = 8'd6; start = 1'b1;
      repeat (25) @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 30 && busy_o; i++) @(negedge clk);
      chk("held_busy_end", int'(busy_o), 0);
      chk("held_q", int'(q_out), 8);
      chk("held_r", int'(r_out), 2);

      // Strided sweep, checking the division identity directly.
      for (int a = 0; a <= 255; a = (a == 252) ? 255 : ((a > 252) ? 256 : a + 9)) begin
         for (int b = 1; b <= 255; b = (b == 249) ? 255 : ((b > 249) ? 256 : b + 8)) begin
            op(a, b, bc);
            chk("sweep_busy", bc, 10);
            chk("sweep_ident", int'(q_out) * b + int'(r_out), a);
            chk("sweep_rltb", int'(int'(r_out) < b), 1);
         end
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Overall time bound.
   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation did not complete, got running expected done");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
